fetch_sequencer: RTL

Instruction-fetch controller that sequences the program counter into the combinational `InstructionMemory` and buffers fetched words for the decode stage. It drives `adr` every cycle, captures `Instruction` with its PC into a 2-entry FIFO, and presents them through a valid/ready handshake. It accepts branch redirects, which flush the FIFO, and flags out-of-range or misaligned PCs as a fetch fault. It sits between the PC/branch logic and decode in the processor datapath.

---
 rtl/fetch_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the PC into a combinational instruction
// memory, buffers {pc, instr} in a 2-entry FIFO, handles redirects and PC faults.
//
// state | meaning
// RUN   | fetching sequentially from pc, pushing into the FIFO when there is room
// FAULT | halted on an illegal pc; only a redirect or reset leaves this state
module fetch_sequencer #(
    parameter int          MEM_SIZE = 16,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] adr,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);

    localparam logic [63:0] MEM_BYTES = 64'(MEM_SIZE) * 64'd4;

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic [63:0] fault_pc_q, fault_pc_next;
    logic [1:0]  count, count_next;
    logic        rd_ptr, rd_ptr_next;
    logic        wr_ptr, wr_ptr_next;
    logic [63:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        pop, push, legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            fault_pc_q <= 64'h0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            fault_pc_q <= fault_pc_next;
            count      <= count_next;
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
        end
    end

    // Payload storage needs no reset: out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= Instruction;
        end
    end

    always_comb begin
        pop   = (count != 2'd0) && out_ready;
        legal = (pc[1:0] == 2'b00) && (pc < MEM_BYTES);
        push  = (state == RUN) && legal && ((count < 2'd2) || pop) && !redirect_valid;

        state_next    = state;
        pc_next       = pc;
        fault_pc_next = fault_pc_q;
        count_next    = count;
        rd_ptr_next   = rd_ptr;
        wr_ptr_next   = wr_ptr;

        if (redirect_valid) begin
            // A pop in this cycle still completes for decode; its entry goes with the flush.
            state_next  = RUN;
            pc_next     = redirect_pc;
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            if (push) begin
                pc_next     = pc + 64'd4;
                wr_ptr_next = ~wr_ptr;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr;
            end
            if (push && !pop) begin
                count_next = count + 2'd1;
            end else if (pop && !push) begin
                count_next = count - 2'd1;
            end
            if ((state == RUN) && !legal) begin
                state_next    = FAULT;
                fault_pc_next = pc;
            end
        end
    end

    assign adr       = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign fault     = (state == FAULT);
    assign fault_pc  = fault_pc_q;

endmodule
